// File: rtl/char_lcd_frame_ctrl.sv
// char_lcd_frame_ctrl: HD44780 8-bit write-only driver; power-up wait, init commands, then row-by-row frame redraws.
// Latency: an accepted frame starts its first slot on the next cycle and takes ROWS*(COLS+1) slots to draw.
// Backpressure: frame_ready is high only in IDLE; frame_valid seen at any other time is ignored, not queued.
module char_lcd_frame_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int T_SETUP      = 200,
  parameter int T_EN         = 1600,
  parameter int T_HOLD       = 200,
  parameter int T_PWRUP      = 20000,
  parameter int T_CLEAR      = 4000,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                     LCDCLK,
  input  logic                     PRESETn,
  input  logic [8*COLS*ROWS-1:0]   frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic                     busy,
  output logic                     LCD_RS,
  output logic                     LCD_RW,
  output logic                     LCD_EN,
  output logic [7:0]               LCD_DATA
);

  localparam int SLOT = T_SETUP + T_EN + T_HOLD;
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int WMAX = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
  localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT - 1);
  localparam logic [SW-1:0] EN_FIRST   = SW'(T_SETUP);
  localparam logic [SW-1:0] EN_LAST    = SW'(T_SETUP + T_EN - 1);
  localparam logic [WW-1:0] PWRUP_LAST = WW'((T_PWRUP > 0) ? T_PWRUP - 1 : 0);
  localparam logic [WW-1:0] CLEAR_LAST = WW'((T_CLEAR > 0) ? T_CLEAR - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [7:0]    ROW2_BASE  = 8'(COLS);
  localparam logic [7:0]    ROW3_BASE  = 8'(64 + COLS);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_CLRWAIT, S_IDLE, S_ROW_ADDR, S_CHAR
  } state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [WW-1:0]            wait_q, wait_d;
  logic [1:0]               idx_q, idx_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [8*COLS*ROWS-1:0]   shadow_q, shadow_d;
  logic                     have_q, have_d;
  logic                     rs_q, rs_d;
  logic                     en_q, en_d;
  logic [7:0]               data_q, data_d;

  logic                     slot_end;
  logic [1:0]               row2;
  logic [7:0]               row_base;
  logic [7:0]               char_byte;
  int                       char_idx;

  assign frame_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign LCD_RS      = rs_q;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_q;
  assign LCD_DATA    = data_q;

  // State, counters, shadow frame and registered bus outputs.
  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_PWRUP;
      slot_q   <= '0;
      wait_q   <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      shadow_q <= '0;
      have_q   <= 1'b0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      shadow_q <= shadow_d;
      have_q   <= have_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      data_q   <= data_d;
    end
  end

  // Next-state: sequence power-up, init, idle/accept and the per-row draw walk.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    shadow_d = shadow_q;
    have_d   = have_q;
    slot_end = (slot_q == SLOT_LAST);
    case (state_q)
      S_PWRUP: begin
        if (wait_q == PWRUP_LAST) begin
          state_d = S_INIT;
          wait_d  = '0;
          slot_d  = '0;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_INIT: begin
        if (slot_end) begin
          slot_d = '0;
          if (idx_q == 2'd3) begin
            // The clear command needs extra settle time before anything else.
            state_d = (T_CLEAR == 0) ? S_IDLE : S_CLRWAIT;
            wait_d  = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_CLRWAIT: begin
        if (wait_q == CLEAR_LAST) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_IDLE: begin
        if (frame_valid) begin
          shadow_d = frame_data;
          have_d   = 1'b1;
          state_d  = S_ROW_ADDR;
          row_d    = '0;
          col_d    = '0;
          slot_d   = '0;
        end else if ((AUTO_REFRESH != 0) && have_q) begin
          state_d = S_ROW_ADDR;
          row_d   = '0;
          col_d   = '0;
          slot_d  = '0;
        end
      end
      S_ROW_ADDR: begin
        if (slot_end) begin
          slot_d  = '0;
          col_d   = '0;
          state_d = S_CHAR;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_CHAR: begin
        if (slot_end) begin
          slot_d = '0;
          if (col_q != COL_LAST) begin
            col_d = col_q + CW'(1);
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + RW'(1);
            col_d   = '0;
            state_d = S_ROW_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // Bus decode from the next state so RS/DATA/EN are flopped and stable for the whole slot.
  always_comb begin
    rs_d      = 1'b0;
    en_d      = 1'b0;
    data_d    = 8'h00;
    row2      = 2'(row_d);
    row_base  = 8'h00;
    char_byte = 8'h00;
    char_idx  = int'(row_d) * COLS + int'(col_d);
    case (row2)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = ROW2_BASE;
      default: row_base = ROW3_BASE;
    endcase
    for (int i = 0; i < COLS * ROWS; i++) begin
      if (i == char_idx) char_byte = shadow_d[8*i +: 8];
    end
    case (state_d)
      S_INIT: begin
        en_d = (slot_d >= EN_FIRST) && (slot_d <= EN_LAST);
        case (idx_d)
          2'd0:    data_d = 8'h38;
          2'd1:    data_d = 8'h0C;
          2'd2:    data_d = 8'h06;
          default: data_d = 8'h01;
        endcase
      end
      S_ROW_ADDR: begin
        en_d   = (slot_d >= EN_FIRST) && (slot_d <= EN_LAST);
        data_d = 8'h80 | row_base;
      end
      S_CHAR: begin
        en_d   = (slot_d >= EN_FIRST) && (slot_d <= EN_LAST);
        rs_d   = 1'b1;
        data_d = char_byte;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_char_lcd_frame_ctrl.sv
// tb_char_lcd_frame_ctrl: directed bench for the LCD frame driver, one plain and one auto-refresh instance.
// Latency: outputs sampled on the falling edge, inputs driven there too, so the DUT sees them on the next rise.
// Backpressure: producer holds frame_valid until it observes frame_ready.
module tb_char_lcd_frame_ctrl;

  localparam int COLS    = 2;
  localparam int ROWS    = 2;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_PWRUP = 10;
  localparam int T_CLEAR = 20;
  localparam int SLOT    = T_SETUP + T_EN + T_HOLD;

  logic        LCDCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready, busy, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0]  LCD_DATA;
  logic [31:0] frame_data_ar = '0;
  logic        frame_valid_ar = 1'b0;
  logic        frame_ready_ar, busy_ar, LCD_RS_ar, LCD_RW_ar, LCD_EN_ar;
  logic [7:0]  LCD_DATA_ar;

  int checks = 0;
  int errors = 0;

  always #5 LCDCLK = ~LCDCLK;

  char_lcd_frame_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_PWRUP(T_PWRUP), .T_CLEAR(T_CLEAR), .AUTO_REFRESH(0)
  ) dut (
    .LCDCLK(LCDCLK), .PRESETn(PRESETn), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
  );

  char_lcd_frame_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_PWRUP(T_PWRUP), .T_CLEAR(T_CLEAR), .AUTO_REFRESH(1)
  ) dut_ar (
    .LCDCLK(LCDCLK), .PRESETn(PRESETn), .frame_data(frame_data_ar), .frame_valid(frame_valid_ar),
    .frame_ready(frame_ready_ar), .busy(busy_ar), .LCD_RS(LCD_RS_ar), .LCD_RW(LCD_RW_ar),
    .LCD_EN(LCD_EN_ar), .LCD_DATA(LCD_DATA_ar)
  );

  typedef struct {
    logic [31:0] frame;      // word offered on frame_data
    logic [31:0] post_data;  // frame_data driven right after the accept
    bit          offer_next; // hold valid with the next frame during the draw
    logic [31:0] next_frame;
    logic [7:0]  c0, c1, c2, c3; // expected chars (r0c0, r0c1, r1c0, r1c1)
  } vec_t;

  // Compare one instance's whole bus/handshake against expectations.
  task automatic chk(input bit sel, input logic rs, input logic en, input logic [7:0] data,
                     input logic rdy, input logic bsy, input string name);
    logic [12:0] act, exp;
    if (sel) act = {LCD_RS_ar, LCD_RW_ar, LCD_EN_ar, LCD_DATA_ar, frame_ready_ar, busy_ar};
    else     act = {LCD_RS, LCD_RW, LCD_EN, LCD_DATA, frame_ready, busy};
    exp = {rs, 1'b0, en, data, rdy, bsy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got rs/rw/en/data/rdy/busy=%b/%b/%b/%h/%b/%b required %b/%b/%b/%h/%b/%b",
               name, sel, act[12], act[11], act[10], act[9:2], act[1], act[0],
               exp[12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Six slots of one frame; first sample taken now unless first_wait.
  task automatic check_frame(input bit sel, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3, input bit first_wait,
                             input bit inject, input logic [31:0] inj_frame, input string name);
    logic       rs;
    logic [7:0] d;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0:       begin rs = 1'b0; d = 8'h80; end
        1:       begin rs = 1'b1; d = c0;    end
        2:       begin rs = 1'b1; d = c1;    end
        3:       begin rs = 1'b0; d = 8'hC0; end
        4:       begin rs = 1'b1; d = c2;    end
        default: begin rs = 1'b1; d = c3;    end
      endcase
      for (int k = 0; k < SLOT; k++) begin
        if (first_wait || s > 0 || k > 0) @(negedge LCDCLK);
        if (inject && (s * SLOT + k) == 20) begin
          frame_valid = 1'b1;
          frame_data  = inj_frame;
        end
        chk(sel, rs, (k >= T_SETUP && k < T_SETUP + T_EN), d, 1'b0, 1'b1,
            $sformatf("%s s%0d k%0d", name, s, k));
      end
    end
  endtask

  // Power-up idle, four init slots, clear wait, then IDLE; called right after reset release.
  task automatic run_init(input string name);
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    #1;
    chk(0, 0, 0, 8'h00, 0, 1, {name, " pwrup0"});
    chk(1, 0, 0, 8'h00, 0, 1, {name, " pwrup0"});
    for (int i = 1; i < T_PWRUP; i++) begin
      @(negedge LCDCLK);
      chk(0, 0, 0, 8'h00, 0, 1, $sformatf("%s pwrup%0d", name, i));
      chk(1, 0, 0, 8'h00, 0, 1, $sformatf("%s pwrup%0d", name, i));
    end
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < SLOT; k++) begin
        @(negedge LCDCLK);
        chk(0, 0, (k >= T_SETUP && k < T_SETUP + T_EN), cmds[n], 0, 1, $sformatf("%s init%0d k%0d", name, n, k));
        chk(1, 0, (k >= T_SETUP && k < T_SETUP + T_EN), cmds[n], 0, 1, $sformatf("%s init%0d k%0d", name, n, k));
      end
    end
    for (int i = 0; i < T_CLEAR; i++) begin
      @(negedge LCDCLK);
      chk(0, 0, 0, 8'h00, 0, 1, $sformatf("%s clrwait%0d", name, i));
      chk(1, 0, 0, 8'h00, 0, 1, $sformatf("%s clrwait%0d", name, i));
    end
    @(negedge LCDCLK);
    chk(0, 0, 0, 8'h00, 1, 0, {name, " idle"});
    chk(1, 0, 0, 8'h00, 1, 0, {name, " idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    vecs[0] = '{32'h44434241, 32'h5A5A5A5A, 1'b0, 32'h0, 8'h41, 8'h42, 8'h43, 8'h44};
    vecs[1] = '{32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 32'h34333231, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    vecs[2] = '{32'h34333231, 32'h34333231, 1'b0, 32'h0, 8'h31, 8'h32, 8'h33, 8'h34};
    vecs[3] = '{32'h00FF7E20, 32'h00FF7E20, 1'b0, 32'h0, 8'h20, 8'h7E, 8'hFF, 8'h00};

    // Reset values while PRESETn is held low.
    repeat (2) @(negedge LCDCLK);
    chk(0, 0, 0, 8'h00, 0, 1, "reset");
    chk(1, 0, 0, 8'h00, 0, 1, "reset");
    @(negedge LCDCLK);
    PRESETn = 1'b1;
    run_init("boot");

    // Frame table on the plain instance; each iteration starts at an IDLE sample point.
    for (int i = 0; i < 4; i++) begin
      frame_valid = 1'b1;
      frame_data  = vecs[i].frame;
      @(negedge LCDCLK);
      frame_valid = 1'b0;
      frame_data  = vecs[i].post_data;
      check_frame(0, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, 1'b0,
                  vecs[i].offer_next, vecs[i].next_frame, $sformatf("frame%0d", i));
      @(negedge LCDCLK);
      chk(0, 0, 0, 8'h00, 1, 0, $sformatf("frame%0d done", i));
    end

    // Without auto-refresh the plain instance stays idle; the other has no frame yet.
    for (int i = 0; i < 3; i++) begin
      @(negedge LCDCLK);
      chk(0, 0, 0, 8'h00, 1, 0, "no refresh");
      chk(1, 0, 0, 8'h00, 1, 0, "ar no frame");
    end

    // Auto-refresh: draw, one IDLE cycle, redraw, then a new frame taken in the gap.
    frame_valid_ar = 1'b1;
    frame_data_ar  = 32'h44434241;
    @(negedge LCDCLK);
    frame_valid_ar = 1'b0;
    frame_data_ar  = 32'h0;
    check_frame(1, 8'h41, 8'h42, 8'h43, 8'h44, 1'b0, 1'b0, 32'h0, "ar draw");
    @(negedge LCDCLK);
    chk(1, 0, 0, 8'h00, 1, 0, "ar gap1");
    check_frame(1, 8'h41, 8'h42, 8'h43, 8'h44, 1'b1, 1'b0, 32'h0, "ar redraw");
    @(negedge LCDCLK);
    chk(1, 0, 0, 8'h00, 1, 0, "ar gap2");
    frame_valid_ar = 1'b1;
    frame_data_ar  = 32'h5A5A5A5A;
    @(negedge LCDCLK);
    frame_valid_ar = 1'b0;
    check_frame(1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 32'h0, "ar new");
    @(negedge LCDCLK);
    chk(1, 0, 0, 8'h00, 1, 0, "ar gap3");
    check_frame(1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 32'h0, "ar new redraw");

    // Asynchronous reset in the middle of an EN pulse of a data slot.
    @(negedge LCDCLK);
    frame_valid = 1'b1;
    frame_data  = 32'h44434241;
    @(negedge LCDCLK);
    frame_valid = 1'b0;
    for (int i = 0; i < 11; i++) @(negedge LCDCLK);
    chk(0, 1, 1, 8'h41, 0, 1, "pre-reset en");
    #2 PRESETn = 1'b0;
    #1;
    chk(0, 0, 0, 8'h00, 0, 1, "async reset");
    chk(1, 0, 0, 8'h00, 0, 1, "async reset");
    @(negedge LCDCLK);
    PRESETn = 1'b1;
    run_init("reboot");

    // The remembered frame is gone after reset, so no auto-refresh starts.
    for (int i = 0; i < 3; i++) begin
      @(negedge LCDCLK);
      chk(1, 0, 0, 8'h00, 1, 0, "ar after reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
